spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//   Rate decoder at the output end of the SNN: the inverse of the input spike encoders.
//   Counts spikes per output neuron over a fixed window of WINDOW enabled cycles.
//   At the end of each window it reports the per-channel counts and a winner class index.
//   Sits between output_spikes of the network and downstream readout/IO logic.
// PARAMETERS
//   N_CH   = 2   number of spike channels (output neurons), >= 2
//   WINDOW = 16  window length in enabled clock cycles, >= 2
//   CNT_W  = 5   per-channel counter width; counters saturate at 2^CNT_W-1
//   IDX_W  = 1   width of winner index, = $clog2(N_CH)
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            asynchronous, active-low reset
//   enable     in   1            1 = decode window running; 0 = idle/abort
//   spikes     in   N_CH         one spike bit per channel per cycle
//   out_ready  in   1            consumer accepts result when out_valid & out_ready
//   out_valid  out  1            result registers hold an unconsumed window result
//   counts     out  N_CH*CNT_W   latched counts, channel i at [i*CNT_W +: CNT_W]
//   winner     out  IDX_W        channel with highest count; lowest index wins ties
//   tie        out  1            max count shared by >1 channel
//   silent     out  1            all counts zero in reported window
//   overrun    out  1            sticky: a result was overwritten before being consumed
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, wcnt=0, accumulators=0, out_valid=0,
//     counts=0, winner=0, tie=0, silent=0, overrun=0.
//   FSM: IDLE -> COUNT when enable=1; COUNT -> IDLE when enable=0.
//   IDLE: accumulators and wcnt held at 0; spikes ignored; result regs and out_valid untouched.
//   COUNT, each cycle: acc[i] += spikes[i], saturating at 2^CNT_W-1; wcnt += 1.
//   The first COUNT cycle is the cycle in which enable is first sampled 1; that cycle's spikes count.
//   Window end (COUNT and wcnt==WINDOW-1):
//     - acc + this cycle's spikes are latched into counts;
//     - winner/tie/silent are computed from those same values;
//     - out_valid=1 from the next cycle;
//     - acc and wcnt clear, and the next window starts immediately with no gap cycle.
//   Latency: result visible 1 cycle after the last window cycle's edge.
//   Handshake: out_valid stays 1 until a cycle with out_ready=1, which clears it.
//     Result regs hold their value while out_valid=1, unless overwritten by the next window end.
//   Window end while out_valid=1 and out_ready=0: result regs are overwritten, out_valid stays 1,
//     and overrun is set. overrun clears only by reset.
//   Window end in the same cycle as out_valid & out_ready: the new result wins, out_valid stays 1,
//     and no overrun is flagged.
//   enable drops mid-window: partial counts are discarded (acc=0, wcnt=0), no result is produced,
//     and a pending out_valid is unaffected.
//   Winner rule: index of the max count; on equality the lowest index wins; tie=1 if the max is shared.
//     All zero: winner=0, tie=1, silent=1.
//   Saturation: a channel at 2^CNT_W-1 stays there; other channels keep counting.
// TESTING
//   1 Reset mid-window (enable=1, acc nonzero), reset pulsed low -> all outputs 0 at once (async), IDLE.
//   2 WINDOW=16, ch0 spikes every cycle, ch1 every 4th cycle, out_ready=1
//     -> counts={4,16}, winner=0, tie=0, out_valid 1 cycle after cycle 16.
//   3 Both channels 5 spikes in window -> winner=0, tie=1, silent=0; no spikes -> silent=1, tie=1.
//   4 out_ready=0 across two windows -> overrun=1 and second window's counts shown;
//     ready on the end cycle -> no overrun.
//   5 enable low at cycle 10 then high -> no out_valid; next result counts only the new 16 cycles.
//   6 CNT_W=3, ch1 spikes 16/16 -> count saturates at 7; ch0 counts 3 -> winner=1.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Rate decoder at the output of the SNN. Counts spikes per output neuron over
//   a window of WINDOW enabled cycles and, at each window end, latches the
//   per-channel counts plus a winner class index for downstream readout.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   enable     in   1 = window running, 0 = idle / abort current window
//   spikes     in   [N_CH]       one spike bit per channel per cycle
//   out_ready  in   consumer accepts result when out_valid & out_ready
//   out_valid  out  result registers hold an unconsumed window result
//   counts     out  [N_CH*CNT_W] latched counts, channel i at [i*CNT_W +: CNT_W]
//   winner     out  [IDX_W]      highest-count channel, lowest index on ties
//   tie        out  max count shared by more than one channel
//   silent     out  all counts zero in the reported window
//   overrun    out  sticky: a result was overwritten before being consumed

// Per-channel saturating accumulator. sum_o is the count including this
// cycle's spike; it is what gets latched on the window-end cycle.
module spike_rate_acc #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             spike_i,
  output logic [CNT_W-1:0] sum_o
);
  logic [CNT_W-1:0] acc_q, acc_d;

  always_comb begin
    if (&acc_q) sum_o = acc_q;
    else        sum_o = acc_q + {{(CNT_W-1){1'b0}}, spike_i};
    acc_d = clr_i ? '0 : sum_o;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

module spike_rate_decoder #(
  parameter int N_CH   = 2,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5,
  parameter int IDX_W  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_CH-1:0]         spikes,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [N_CH*CNT_W-1:0]   counts,
  output logic [IDX_W-1:0]        winner,
  output logic                    tie,
  output logic                    silent,
  output logic                    overrun
);
  localparam int WCNT_W = $clog2(WINDOW);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e                         state_q, state_d;
  logic [WCNT_W-1:0]              wcnt_q, wcnt_d;
  logic [N_CH-1:0][CNT_W-1:0]     sum;
  logic                           win_end, acc_clr;

  logic [N_CH-1:0][CNT_W-1:0]     counts_q;
  logic [IDX_W-1:0]               winner_q, winner_d;
  logic                           tie_q, tie_d, silent_q, silent_d;
  logic                           valid_q, valid_d, overrun_q, overrun_d;
  logic [CNT_W-1:0]               max_v;
  logic                           seen;

  // The cycle in which enable is first sampled high already counts, so
  // accumulation is keyed off enable itself rather than the registered state.
  // wcnt is only nonzero while in COUNT, so the state term is just a guard.
  assign win_end = (state_q == COUNT) && enable && (wcnt_q == WCNT_W'(WINDOW-1));
  assign acc_clr = !enable || win_end;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = COUNT;
      COUNT:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (acc_clr) wcnt_d = '0;
    else         wcnt_d = wcnt_q + WCNT_W'(1);
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      spike_rate_acc #(.CNT_W(CNT_W)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (acc_clr),
        .spike_i (spikes[g]),
        .sum_o   (sum[g])
      );
    end
  endgenerate

  // Winner/tie/silent from the same values that get latched into counts.
  // Strict '>' keeps the lowest index on equality.
  always_comb begin
    max_v    = sum[0];
    winner_d = '0;
    for (int i = 1; i < N_CH; i++) begin
      if (sum[i] > max_v) begin
        max_v    = sum[i];
        winner_d = IDX_W'(i);
      end
    end
    tie_d = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sum[i] == max_v) begin
        if (seen) tie_d = 1'b1;
        seen = 1'b1;
      end
    end
    silent_d = (max_v == '0);
  end

  // A new result always wins; overrun only when the old one was neither
  // consumed earlier nor consumed in this same cycle.
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (win_end) begin
      valid_d = 1'b1;
      if (valid_q && !out_ready) overrun_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      counts_q  <= '0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      silent_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (win_end) begin
        counts_q <= sum;
        winner_q <= winner_d;
        tie_q    <= tie_d;
        silent_q <= silent_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign counts    = counts_q;
  assign winner    = winner_q;
  assign tie       = tie_q;
  assign silent    = silent_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (CNT_W=5 and CNT_W=3) share
// stimulus; a window-level reference model tracks expected results.
module tb_spike_rate_decoder;
  localparam int WINDOW = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] spikes = '0;
  logic       out_ready = 1'b0;

  logic       v1, t1, s1, o1, w1;
  logic [9:0] c1;
  logic       v2, t2, s2, o2, w2;
  logic [5:0] c2;

  always #5 clk = ~clk;

  spike_rate_decoder #(.N_CH(2), .WINDOW(WINDOW), .CNT_W(5), .IDX_W(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .spikes(spikes), .out_ready(out_ready),
    .out_valid(v1), .counts(c1), .winner(w1), .tie(t1), .silent(s1), .overrun(o1));

  spike_rate_decoder #(.N_CH(2), .WINDOW(WINDOW), .CNT_W(3), .IDX_W(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .spikes(spikes), .out_ready(out_ready),
    .out_valid(v2), .counts(c2), .winner(w2), .tie(t2), .silent(s2), .overrun(o2));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: raw spike totals for the running window, result fields
  // derived from the totals clipped to each instance's counter ceiling.
  int   m_w, m_s0, m_s1;
  logic m_valid, m_ovr;
  int   r_c0 [2];
  int   r_c1 [2];
  logic r_win [2];
  logic r_tie [2];
  logic r_sil [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_s0 = 0; m_s1 = 0;
    m_valid = 1'b0; m_ovr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r_c0[k] = 0; r_c1[k] = 0; r_win[k] = 1'b0; r_tie[k] = 1'b0; r_sil[k] = 1'b0;
    end
  endtask

  task automatic model_latch();
    int mx, a, b;
    for (int k = 0; k < 2; k++) begin
      mx = (k == 0) ? 31 : 7;
      a  = (m_s0 < mx) ? m_s0 : mx;
      b  = (m_s1 < mx) ? m_s1 : mx;
      r_c0[k]  = a;
      r_c1[k]  = b;
      r_win[k] = (b > a);
      r_tie[k] = (a == b);
      r_sil[k] = (a == 0) && (b == 0);
    end
  endtask

  task automatic check_all();
    chk("valid1",   {15'd0, v1}, {15'd0, m_valid});
    chk("valid2",   {15'd0, v2}, {15'd0, m_valid});
    chk("overrun1", {15'd0, o1}, {15'd0, m_ovr});
    chk("overrun2", {15'd0, o2}, {15'd0, m_ovr});
    chk("counts1",  {6'd0, c1}, {6'd0, 5'(r_c1[0]), 5'(r_c0[0])});
    chk("counts2",  {10'd0, c2}, {10'd0, 3'(r_c1[1]), 3'(r_c0[1])});
    chk("winner1",  {15'd0, w1}, {15'd0, r_win[0]});
    chk("winner2",  {15'd0, w2}, {15'd0, r_win[1]});
    chk("tie1",     {15'd0, t1}, {15'd0, r_tie[0]});
    chk("tie2",     {15'd0, t2}, {15'd0, r_tie[1]});
    chk("silent1",  {15'd0, s1}, {15'd0, r_sil[0]});
    chk("silent2",  {15'd0, s2}, {15'd0, r_sil[1]});
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input logic en, input logic [1:0] sp, input logic rdy);
    logic ended;
    enable = en; spikes = sp; out_ready = rdy;
    @(posedge clk);
    ended = 1'b0;
    if (!en) begin
      m_w = 0; m_s0 = 0; m_s1 = 0;
    end else begin
      m_s0 += int'(sp[0]);
      m_s1 += int'(sp[1]);
      m_w++;
      if (m_w == WINDOW) begin
        ended = 1'b1;
        model_latch();
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_w = 0; m_s0 = 0; m_s1 = 0;
      end
    end
    if (!ended && m_valid && rdy) m_valid = 1'b0;
    #1;
    check_all();
  endtask

  // Async reset pulse between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    #1 reset = 1'b1;
    step(1'b0, 2'b00, 1'b0);

    // ch0 every cycle, ch1 every 4th cycle
    for (int i = 0; i < WINDOW; i++) step(1'b1, {(i % 4 == 0), 1'b1}, 1'b1);
    chk("t2_counts", {6'd0, c1}, {6'd0, 5'd4, 5'd16});
    chk("t2_winner", {15'd0, w1}, 16'd0);
    chk("t2_tie",    {15'd0, t1}, 16'd0);
    chk("t2_valid",  {15'd0, v1}, 16'd1);

    // reset mid-window with accumulators nonzero
    for (int i = 0; i < 8; i++) step(1'b1, 2'b11, 1'b0);
    pulse_reset();
    chk("t1_valid", {15'd0, v1}, 16'd0);

    // equal counts, then a silent window
    for (int i = 0; i < WINDOW; i++) step(1'b1, (i < 5) ? 2'b11 : 2'b00, 1'b1);
    chk("t3_tie",    {15'd0, t1}, 16'd1);
    chk("t3_winner", {15'd0, w1}, 16'd0);
    chk("t3_silent", {15'd0, s1}, 16'd0);
    for (int i = 0; i < WINDOW; i++) step(1'b1, 2'b00, 1'b1);
    chk("t3_silent0", {15'd0, s1}, 16'd1);
    chk("t3_tie0",    {15'd0, t1}, 16'd1);

    // overrun across two unconsumed windows
    for (int i = 0; i < 2*WINDOW; i++) step(1'b1, 2'($urandom), 1'b0);
    chk("t4_overrun", {15'd0, o1}, 16'd1);
    pulse_reset();
    for (int i = 0; i < WINDOW; i++) step(1'b1, 2'($urandom), 1'b0);
    for (int i = 0; i < WINDOW; i++) step(1'b1, 2'($urandom), (i == WINDOW-1));
    chk("t4_no_overrun", {15'd0, o1}, 16'd0);
    chk("t4_valid",      {15'd0, v1}, 16'd1);

    // abort at cycle 10, then a full fresh window
    for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 1'b1);
    step(1'b0, 2'b11, 1'b1);
    step(1'b0, 2'b11, 1'b1);
    chk("t5_no_valid", {15'd0, v1}, 16'd0);
    for (int i = 0; i < WINDOW; i++) step(1'b1, 2'b01, 1'b0);
    chk("t5_counts", {6'd0, c1}, {6'd0, 5'd0, 5'd16});

    // saturation on the narrow instance
    for (int i = 0; i < WINDOW; i++) step(1'b1, {1'b1, (i < 3)}, 1'b1);
    chk("t6_counts2", {10'd0, c2}, {10'd0, 3'd7, 3'd3});
    chk("t6_winner2", {15'd0, w2}, 16'd1);

    // randomized windows with occasional aborts and random back-pressure
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < WINDOW; i++) begin
        logic [1:0] sp;
        sp = (w % 2 == 0) ? 2'($urandom) : 2'($urandom | $urandom);
        step($urandom_range(0, 39) != 0, sp, $urandom_range(0, 2) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
